// File: rtl/ib_ram_loader_pkg.sv
// Shared definitions for the IB-RAM page loader and its read-side peers.
//   loader_state_e   : loader FSM states
//   make_access_addr : builds an SRAM access address from bank/page fields
//   LANE_CNT_WIDTH   : width of the lane (bank) counter inside a row
package ib_ram_loader_pkg;

  localparam int IB_BANK_NUM        = 4;
  localparam int IB_ADDR_WIDTH      = 8;
  localparam int IB_BANK_ADDR_WIDTH = $clog2(IB_BANK_NUM);
  localparam int IB_PAGE_ADDR_WIDTH = IB_ADDR_WIDTH - IB_BANK_ADDR_WIDTH;
  localparam int IB_PAGE_SIZE       = 4;
  localparam int IB_PAGE_NUM        = 64;
  localparam int LANE_CNT_WIDTH     = IB_BANK_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_e;

  // interleave_type 0: {bank, page}; 1: {page, bank}
  function automatic logic [IB_ADDR_WIDTH-1:0] make_access_addr(
    input logic [IB_BANK_ADDR_WIDTH-1:0] bank,
    input logic [IB_PAGE_ADDR_WIDTH-1:0] page,
    input logic                          interleave_type
  );
    return interleave_type ? {page, bank} : {bank, page};
  endfunction

endpackage

// File: rtl/ib_ram_lane_packer.sv
// Collects consecutive stream entries into one row word, lane 0 first.
//   clk, rst  : clock, synchronous active-high reset (clears counter and word)
//   accept    : an entry is transferred this cycle
//   data      : entry payload
//   clear     : restart at lane 0 (word contents are left as-is; every lane
//               is overwritten before the word is used)
//   word      : packed row, lane k at bits [(k+1)*LANE_W-1 : k*LANE_W]
//   row_full  : combinational pulse when the last lane of a row is accepted
module ib_ram_lane_packer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept,
  input  logic [LANE_W-1:0]       data,
  input  logic                    clear,
  output logic [LANES*LANE_W-1:0] word,
  output logic                    row_full
);

  logic [CNT_W-1:0] lane_cnt;
  logic             last_lane;

  assign last_lane = (lane_cnt == CNT_W'(LANES - 1));
  assign row_full  = accept && last_lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      lane_cnt <= '0;
    end else if (accept) begin
      word[lane_cnt*LANE_W +: LANE_W] <= data;
      lane_cnt <= last_lane ? '0 : lane_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ib_ram_page_loader.sv
// Write-side feeder for the 4-bank interleaved single-port IB-RAM.
// Packs BANK_INTERLEAVE_NUM stream entries per row and writes one row per
// SRAM cycle across [base_page_i, base_page_i+load_len_i), then pulses done_o.
// While idle, rd_addr_i is passed straight through to the SRAM address.
//   sys_clk, rstn   : clock, synchronous ACTIVE-HIGH reset
//   start_i, base_page_i, load_len_i : session request (sampled in IDLE only)
//   s_data_i, s_valid_i, s_ready_o   : entry stream
//   rd_addr_i       : read address forwarded while idle
//   busy_o, done_o, err_o            : session status (err_o sticky until
//                                      the next legal start)
//   sram_wdata_o, sram_addr_o, sram_wen_n_o : SRAM write/access port
//   state_o         : current FSM state, for observation
//
// Stream handshake: an entry transfers on a rising edge where s_valid_i and
// s_ready_o are both high. s_ready_o depends only on registered state, and
// s_valid_i must stay high with s_data_i stable until the transfer happens.
module ib_ram_page_loader
  import ib_ram_loader_pkg::*;
#(
  parameter int BANK_INTERLEAVE_TYPE = 0,
  parameter int BANK_INTERLEAVE_NUM  = IB_BANK_NUM,
  parameter int ADDR_WIDTH           = IB_ADDR_WIDTH,
  parameter int BANK_ADDR_WIDTH      = $clog2(BANK_INTERLEAVE_NUM),
  parameter int PAGE_ADDR_WIDTH      = ADDR_WIDTH - BANK_ADDR_WIDTH,
  parameter int PAGE_SIZE            = IB_PAGE_SIZE,
  parameter int WDATA_SIZE           = PAGE_SIZE * BANK_INTERLEAVE_NUM,
  parameter int PAGE_NUM             = IB_PAGE_NUM
) (
  input  logic                       sys_clk,
  input  logic                       rstn,
  input  logic                       start_i,
  input  logic [PAGE_ADDR_WIDTH-1:0] base_page_i,
  input  logic [PAGE_ADDR_WIDTH:0]   load_len_i,
  input  logic [PAGE_SIZE-1:0]       s_data_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [ADDR_WIDTH-1:0]      rd_addr_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [WDATA_SIZE-1:0]      sram_wdata_o,
  output logic [ADDR_WIDTH-1:0]      sram_addr_o,
  output logic                       sram_wen_n_o,
  output loader_state_e              state_o
);

  localparam logic [PAGE_ADDR_WIDTH+1:0] PAGE_LIMIT = (PAGE_ADDR_WIDTH+2)'(PAGE_NUM);

  loader_state_e state, state_nxt;

  logic [PAGE_ADDR_WIDTH-1:0] base_q;
  logic [PAGE_ADDR_WIDTH-1:0] row_cnt;
  logic [PAGE_ADDR_WIDTH:0]   len_q;
  logic                       err_q;

  logic [PAGE_ADDR_WIDTH+1:0] range_end;
  logic                       range_ok;
  logic                       launch;
  logic                       accept;
  logic                       row_full;
  logic                       last_row;
  logic [WDATA_SIZE-1:0]      row_word;
  logic [PAGE_ADDR_WIDTH-1:0] wr_page;
  logic [ADDR_WIDTH-1:0]      wr_addr;

  // Two extra bits so base+len cannot wrap before the bound check.
  assign range_end = {2'b00, base_page_i} + {1'b0, load_len_i};
  assign range_ok  = (load_len_i != '0) &&
                     ({1'b0, load_len_i} <= PAGE_LIMIT) &&
                     (range_end <= PAGE_LIMIT);

  assign launch   = (state == IDLE) && start_i && range_ok;
  // Built from state directly, not s_ready_o, to keep the decode loop-free.
  assign accept   = s_valid_i && (state == COLLECT);
  assign last_row = ({1'b0, row_cnt} == len_q - 1'b1);
  assign wr_page  = base_q + row_cnt;
  assign wr_addr  = make_access_addr('0, wr_page, BANK_INTERLEAVE_TYPE != 0);

  ib_ram_lane_packer #(
    .LANES  (BANK_INTERLEAVE_NUM),
    .LANE_W (PAGE_SIZE),
    .CNT_W  (LANE_CNT_WIDTH)
  ) u_packer (
    .clk      (sys_clk),
    .rst      (rstn),
    .accept   (accept),
    .data     (s_data_i),
    .clear    (launch),
    .word     (row_word),
    .row_full (row_full)
  );

  always_ff @(posedge sys_clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    s_ready_o    = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    sram_wen_n_o = 1'b1;
    sram_wdata_o = '0;
    sram_addr_o  = wr_addr;
    case (state)
      IDLE: begin
        sram_addr_o = rd_addr_i;
        if (launch) state_nxt = COLLECT;
      end
      COLLECT: begin
        busy_o    = 1'b1;
        s_ready_o = 1'b1;
        if (row_full) state_nxt = WRITE;
      end
      WRITE: begin
        busy_o       = 1'b1;
        sram_wen_n_o = 1'b0;
        sram_wdata_o = row_word;
        state_nxt    = last_row ? DONE : COLLECT;
      end
      DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rstn) begin
      base_q  <= '0;
      len_q   <= '0;
      row_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state == IDLE) && start_i) begin
        if (range_ok) begin
          err_q   <= 1'b0;
          base_q  <= base_page_i;
          len_q   <= load_len_i;
          row_cnt <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if ((state == WRITE) && !last_row) row_cnt <= row_cnt + 1'b1;
    end
  end

  assign err_o   = err_q;
  assign state_o = state;

endmodule

// File: doc/ib_ram_page_loader.md
Name: ib_ram_page_loader

Overview:
Write-side feeder for the 4-bank interleaved single-port IB-RAM. It accepts a valid/ready stream of PAGE_SIZE-bit entries and packs BANK_INTERLEAVE_NUM consecutive entries into one WDATA_SIZE word. It issues one write per page row (all banks written in parallel) across a programmed row range, then pulses done. When idle it passes an external read address straight to the SRAM.

Parameters:
BANK_INTERLEAVE_TYPE, 0, 0: addr={bank,page}; 1: addr={page,bank}
BANK_INTERLEAVE_NUM, 4, banks per row (fixed 4 in this revision)
ADDR_WIDTH, 8, SRAM access address width
BANK_ADDR_WIDTH, $clog2(BANK_INTERLEAVE_NUM), bank field width
PAGE_ADDR_WIDTH, ADDR_WIDTH-BANK_ADDR_WIDTH, page field width
PAGE_SIZE, 4, bits per bank entry
WDATA_SIZE, PAGE_SIZE*BANK_INTERLEAVE_NUM, SRAM write word width
PAGE_NUM, 64, rows per bank

Ports:
sys_clk  in  1  clock; all state changes on rising edge
rstn  in  1  reset: synchronous, active-high
start_i  in  1  begin load session (sampled only in IDLE)
base_page_i  in  PAGE_ADDR_WIDTH  first row to write
load_len_i  in  PAGE_ADDR_WIDTH+1  number of rows, legal 1..PAGE_NUM
s_data_i  in  PAGE_SIZE  stream entry; first entry of a row goes to bank 0
s_valid_i  in  1  stream valid
s_ready_o  out  1  stream ready
rd_addr_i  in  ADDR_WIDTH  read address, forwarded while idle
busy_o  out  1  session active
done_o  out  1  one-cycle pulse, session complete
err_o  out  1  sticky illegal-range flag
sram_wdata_o  out  WDATA_SIZE  to SRAM wdata_i
sram_addr_o  out  ADDR_WIDTH  to SRAM access_addr_i
sram_wen_n_o  out  1  to SRAM wen_n_i, active low

Behaviour:
- Reset (rstn=1 at edge): state IDLE, row_cnt=0, lane_cnt=0, lane buffer=0, err_o=0, done_o=0, busy_o=0, s_ready_o=0, sram_wen_n_o=1, sram_wdata_o=0. Mid-session reset abandons the partial row with no write; rows already written are kept.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - sram_addr_o=rd_addr_i (combinational pass-through); sram_wen_n_o=1.
  - On start_i, check the range. Illegal if load_len_i==0, load_len_i>PAGE_NUM, or base_page_i+load_len_i>PAGE_NUM (sum evaluated at PAGE_ADDR_WIDTH+2 bits). If illegal: err_o<=1, stay IDLE. If legal: err_o<=0, latch base and length, clear counters, go to COLLECT.
- COLLECT:
  - busy_o=1; s_ready_o=1.
  - On each s_valid_i&&s_ready_o: buf[lane_cnt]<=s_data_i (lane k occupies bits [(k+1)*PAGE_SIZE-1:k*PAGE_SIZE]); lane_cnt++.
  - Accepting lane N-1 wraps lane_cnt to 0 and goes to WRITE.
- WRITE (exactly 1 cycle):
  - s_ready_o=0; sram_wen_n_o=0; sram_wdata_o=buf.
  - sram_addr_o: page field=base+row_cnt, bank field=0, placed per BANK_INTERLEAVE_TYPE.
  - Next: if row_cnt==len-1 go to DONE, else row_cnt++ and go to COLLECT.
- DONE (1 cycle): done_o=1; busy_o=1; s_ready_o=0; then go to IDLE.
- Output timing: s_ready_o, sram_wen_n_o, sram_wdata_o and the write address are decoded from registered state only. There is no combinational path from s_valid_i or s_data_i to any sram_* output.
- start_i is ignored outside IDLE. rd_addr_i is ignored while busy.
- Throughput: N+1 cycles per row with continuous valid. Latency from the last accept of a row to the write is 1 cycle.
- Counter wrap: row_cnt never exceeds len-1; lane_cnt wraps modulo N.

Decomposition:
- Package ib_ram_loader_pkg:
  - state enum loader_state_e {IDLE, COLLECT, WRITE, DONE}
  - function make_access_addr(bank, page, interleave_type) → ADDR_WIDTH address; shared with read-side blocks
  - localparam LANE_CNT_WIDTH
- Sub-module ib_ram_lane_packer: lane counter plus buffer. Inputs: accept, data, clear. Outputs: word, row_full pulse.

Test Plan:
- Defaults, base=0, len=1, stream 1,2,3,4 back-to-back → one cycle with wen_n=0, addr=8'h00, wdata=16'h4321; done_o pulses on the following cycle; busy_o low after that.
- TYPE=1, base=5, len=2, stream 8 entries → writes at addr 8'h14 then 8'h18; exactly 2 wen_n low cycles.
- Back-pressure: valid toggles every other cycle → write only after the 4th accept; s_ready_o=0 during WRITE and DONE; no extra captures.
- Errors:
  - len=0 → err_o=1, busy_o stays 0, no write.
  - base=62, len=3 → err_o=1.
  - A following legal start clears err_o.
- Reset mid-row after 2 accepts → no wen_n low; next cycle state IDLE, s_ready_o=0. A new start+4 entries writes the fresh data only.
- Idle pass-through: rd_addr_i=8'hC7 → sram_addr_o=8'hC7, wen_n=1. A second start pulse mid-session → ignored; the first session completes unchanged.
